// File: rtl/pipelined_chunk_adder.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice is resolved per stage,
// with the carry registered between stages and a valid/ready handshake on both ends.
module pipelined_chunk_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int STAGES = (CHUNK < 1) ? 1 : WIDTH / CHUNK;
   localparam int REM    = (CHUNK < 1) ? 1 : WIDTH % CHUNK;

   if (CHUNK < 1 || REM != 0) begin : g_bad_params
      $error("pipelined_chunk_adder: WIDTH must be a positive multiple of CHUNK");
   end

   logic             advance;
   logic             v_q [STAGES];
   logic             c_q [STAGES];
   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   logic [WIDTH-1:0] s_q [STAGES];

   logic last_v_in;
   logic last_a_msb;
   logic last_b_msb;
   logic last_s_msb;
   logic last_c_next;
   logic ovf_reg;

   // The whole pipeline freezes, bubbles included, while the output is stalled.
   assign advance  = !v_q[STAGES-1] || out_ready;
   assign in_ready = advance;

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic             v_in;
      logic             c_in;
      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] b_in;
      logic [WIDTH-1:0] s_in;
      logic [WIDTH-1:0] s_next;
      logic [CHUNK:0]   t_next;
      logic             v_reg;
      logic             c_reg;
      logic [WIDTH-1:0] a_reg;
      logic [WIDTH-1:0] b_reg;
      logic [WIDTH-1:0] s_reg;

      if (gi == 0) begin : g_first
         // Subtraction is A + ~B + 1, so the carry-in is forced high and in_cin ignored.
         assign v_in = in_valid;
         assign a_in = in_a;
         assign b_in = in_sub ? ~in_b : in_b;
         assign c_in = in_sub | in_cin;
         assign s_in = '0;
      end else begin : g_chain
         assign v_in = v_q[gi-1];
         assign a_in = a_q[gi-1];
         assign b_in = b_q[gi-1];
         assign c_in = c_q[gi-1];
         assign s_in = s_q[gi-1];
      end

      assign t_next = {1'b0, a_in[gi*CHUNK +: CHUNK]}
                    + {1'b0, b_in[gi*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, c_in};

      always_comb begin
         s_next = s_in;
         s_next[gi*CHUNK +: CHUNK] = t_next[CHUNK-1:0];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_reg <= 1'b0;
            c_reg <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            s_reg <= '0;
         end else if (advance) begin
            v_reg <= v_in;
            if (v_in) begin
               c_reg <= t_next[CHUNK];
               a_reg <= a_in;
               b_reg <= b_in;
               s_reg <= s_next;
            end
         end
      end

      assign v_q[gi] = v_reg;
      assign c_q[gi] = c_reg;
      assign a_q[gi] = a_reg;
      assign b_q[gi] = b_reg;
      assign s_q[gi] = s_reg;

      if (gi == STAGES - 1) begin : g_last
         assign last_v_in   = v_in;
         assign last_a_msb  = a_in[WIDTH-1];
         assign last_b_msb  = b_in[WIDTH-1];
         assign last_s_msb  = s_next[WIDTH-1];
         assign last_c_next = t_next[CHUNK];
      end
   end

   // Carry into the MSB is recovered as a^b^sum at that bit position.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_reg <= 1'b0;
      end else if (advance && last_v_in) begin
         ovf_reg <= (last_a_msb ^ last_b_msb ^ last_s_msb) ^ last_c_next;
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign out_sum   = s_q[STAGES-1];
   assign out_cout  = c_q[STAGES-1];
   assign out_ovf   = ovf_reg;

endmodule
